// File: rtl/serial_ripple_borrow_subtractor.sv
// serial_ripple_borrow_subtractor: bit-serial unsigned a - b, LSB first, exposing the per-bit borrow chain
module serial_ripple_borrow_subtractor #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  din_valid,
   output logic                  din_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [DATA_WIDTH-1:0] diff,
   output logic                  borrow_out,
   output logic [DATA_WIDTH-1:0] bout_int
);
   localparam int IW = $clog2(DATA_WIDTH + 1);
   localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [DATA_WIDTH-1:0] a_r, b_r, mask;
   logic [IW-1:0] idx;
   logic bin, d, bo;
   always_ff @(posedge clk)
      state <= reset ? IDLE : state_nx;
   always_comb begin
      state_nx = state;
      if (state == IDLE && din_valid) state_nx = RUN;
      else if (state == RUN && idx == LAST) state_nx = DONE;
      else if (state == DONE && dout_ready) state_nx = IDLE;
   end
   assign din_ready  = state == IDLE;
   assign dout_valid = state == DONE;
   // operands shift right so the current bit is always at position 0
   assign mask = DATA_WIDTH'(1) << idx;
   assign d    = a_r[0] ^ b_r[0] ^ bin;
   assign bo   = (~a_r[0] & b_r[0]) | (~(a_r[0] ^ b_r[0]) & bin);
   always_ff @(posedge clk) begin
      if (reset) begin
         a_r        <= '0;
         b_r        <= '0;
         diff       <= '0;
         bout_int   <= '0;
         borrow_out <= 1'b0;
         bin        <= 1'b0;
         idx        <= '0;
      end else if (state == IDLE && din_valid) begin
         a_r        <= a;
         b_r        <= b;
         diff       <= '0;
         bout_int   <= '0;
         borrow_out <= 1'b0;
         bin        <= 1'b0;
         idx        <= '0;
      end else if (state == RUN) begin
         a_r      <= a_r >> 1;
         b_r      <= b_r >> 1;
         diff     <= diff | (mask & {DATA_WIDTH{d}});
         bout_int <= bout_int | (mask & {DATA_WIDTH{bo}});
         bin      <= bo;
         idx      <= idx + 1'b1;
         if (idx == LAST) borrow_out <= bo;
      end
   end
endmodule

// File: tb/tb_serial_ripple_borrow_subtractor.sv
// tb_serial_ripple_borrow_subtractor: directed vector table, random ops against an arithmetic model, reset mid-run
module tb_serial_ripple_borrow_subtractor;
   localparam int W = 8;
   logic clk = 0, reset = 1, din_valid = 0, dout_ready = 1;
   logic din_ready, dout_valid, borrow_out;
   logic [W-1:0] a = '0, b = '0, diff, bout_int;
   int passed = 0, total = 0;

   always #5 clk = ~clk;

   serial_ripple_borrow_subtractor #(.DATA_WIDTH(W)) dut (
      .clk(clk), .reset(reset), .din_valid(din_valid), .din_ready(din_ready),
      .a(a), .b(b), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .diff(diff), .borrow_out(borrow_out), .bout_int(bout_int)
   );

   typedef struct {
      logic [W-1:0] a, b, diff;
      logic         bo;
      logic [W-1:0] bout;
      int           hold;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // bit i borrows out iff the low i+1 bits of a are smaller than those of b
   function automatic void model(input int ai, input int bi, output logic [W-1:0] d,
                                 output logic bo, output logic [W-1:0] bv);
      d  = W'(ai - bi);
      bo = ai < bi;
      for (int i = 0; i < W; i++) bv[i] = (ai % (1 << (i + 1))) < (bi % (1 << (i + 1)));
   endfunction

   task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input int hold,
                         input logic [W-1:0] ed, input logic eb, input logic [W-1:0] ebout);
      int n = 0;
      while (!din_ready && n < 50) begin tick(); n++; end
      chk("din_ready_idle", din_ready, 1);
      dout_ready = (hold == 0);
      din_valid = 1;
      a = ai;
      b = bi;
      tick();
      din_valid = 0;
      chk("din_ready_run", din_ready, 0);
      n = 0;
      while (!dout_valid && n < 100) begin
         a = W'($urandom);
         b = W'($urandom);
         tick();
         n++;
      end
      chk("latency", n, W);
      chk("diff", diff, ed);
      chk("borrow_out", borrow_out, eb);
      chk("bout_int", bout_int, ebout);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_valid", dout_valid, 1);
         chk("hold_ready", din_ready, 0);
         chk("hold_diff", diff, ed);
         chk("hold_bout", bout_int, ebout);
         chk("hold_borrow", borrow_out, eb);
      end
      dout_ready = 1;
      din_valid = 1;
      tick();
      chk("post_ready", din_ready, 1);
      chk("post_valid", dout_valid, 0);
      din_valid = 0;
   endtask

   initial begin
      vec_t vecs[8];
      logic [W-1:0] md, mb;
      logic mo;
      int ra, rb;
      vecs[0] = '{8'd200, 8'd55, 8'h91, 1'b0, 8'h37, 0};
      vecs[1] = '{8'd10, 8'd20, 8'hF6, 1'b1, 8'hF4, 0};
      vecs[2] = '{8'd0, 8'd1, 8'hFF, 1'b1, 8'hFF, 0};
      vecs[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 8'h00, 0};
      vecs[4] = '{8'd200, 8'd55, 8'h91, 1'b0, 8'h37, 5};
      vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 8'h00, 1};
      vecs[6] = '{8'h00, 8'hFF, 8'h01, 1'b1, 8'hFF, 2};
      vecs[7] = '{8'h80, 8'h01, 8'h7F, 1'b0, 8'h7F, 0};
      tick();
      tick();
      chk("rst_ready_in_reset", din_ready, 1);
      reset = 0;
      tick();
      chk("rst_din_ready", din_ready, 1);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_diff", diff, 0);
      chk("rst_bout", bout_int, 0);
      chk("rst_borrow", borrow_out, 0);
      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].diff, vecs[i].bo, vecs[i].bout);
      for (int k = 0; k < 40; k++) begin
         ra = $urandom_range(0, 255);
         rb = (k % 8 == 0) ? ra : $urandom_range(0, 255);
         model(ra, rb, md, mo, mb);
         run_op(W'(ra), W'(rb), $urandom_range(0, 3), md, mo, mb);
      end
      // reset three bits into a run that has already produced nonzero partial results
      din_valid = 1;
      a = 8'h00;
      b = 8'hFF;
      tick();
      din_valid = 0;
      tick();
      tick();
      tick();
      reset = 1;
      tick();
      reset = 0;
      chk("mid_rst_ready", din_ready, 1);
      chk("mid_rst_valid", dout_valid, 0);
      chk("mid_rst_diff", diff, 0);
      chk("mid_rst_bout", bout_int, 0);
      chk("mid_rst_borrow", borrow_out, 0);
      run_op(8'd3, 8'd1, 0, 8'h02, 1'b0, 8'h00);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
